// File: rtl/mask_index_encoder.sv
// ----------------------------------------------------------------------------
// mask_index_encoder
//
// Purpose
//   Turns a WIDTH-bit multi-hot mask back into a stream of SIZE-bit binary
//   indices, one index per output beat, in priority order. This is the inverse
//   of a binary-to-one-hot decoder. A typical use is draining a vector of
//   pending requests one request at a time.
//
//   An all-zero mask still produces exactly one beat. That beat has
//   out_none=1, out_index=0 and out_last=1, so every accepted mask is
//   acknowledged downstream.
//
// Configuration macro
//   ENCODER_MSB_FIRST_EN
//     Undefined (default): beats are emitted lowest set bit first.
//     Defined:             beats are emitted highest set bit first.
//   out_last, out_none and the handshakes behave the same in both builds.
//
// Parameters
//   SIZE   index width in bits (>= 1)
//   WIDTH  mask width; only WIDTH == 1 << SIZE is supported
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      in_mask is valid
//   in_ready   out  1      a mask can be accepted this cycle
//   in_mask    in   WIDTH  multi-hot mask to encode
//   out_valid  out  1      out_index/out_last/out_none are valid
//   out_ready  in   1      downstream accepts the current beat
//   out_index  out  SIZE   binary index of the current set bit
//   out_last   out  1      current beat is the final beat of its mask
//   out_none   out  1      accepted mask was all-zero; beat has no index
// ----------------------------------------------------------------------------
module mask_index_encoder #(
  parameter int SIZE  = 3,
  parameter int WIDTH = 1 << SIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_index,
  output logic             out_last,
  output logic             out_none
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Registered state. rem_r holds every bit not yet emitted, including the
  // bit of the beat currently presented on out_index.
  state_t           state_r;
  logic [WIDTH-1:0] rem_r;

  // Next-state values, computed combinationally.
  state_t           state_s;
  logic [WIDTH-1:0] rem_s;
  logic             valid_s;
  logic [SIZE-1:0]  index_s;
  logic             last_s;
  logic             none_s;

  // Handshake qualifiers.
  logic             beat_fire_s;
  logic             accept_s;
  logic [WIDTH-1:0] rem_after_s;

  // Returns the index of the highest-priority set bit of m, or 0 if m is 0.
  // The loop direction chooses which bit wins: the index written last is
  // the one that is kept.
  function automatic logic [SIZE-1:0] prio_index(input logic [WIDTH-1:0] m);
    logic [SIZE-1:0] idx;
    idx = {SIZE{1'b0}};
`ifdef ENCODER_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (m[i]) begin
        idx = SIZE'(i);
      end else begin
        idx = idx;
      end
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (m[i]) begin
        idx = SIZE'(i);
      end else begin
        idx = idx;
      end
    end
`endif
    return idx;
  endfunction

  // Returns 1 when m has at most one set bit. A zero mask therefore also
  // reports "last", which gives the single out_none beat its out_last=1.
  function automatic logic at_most_one(input logic [WIDTH-1:0] m);
    return ((m & (m - {{(WIDTH-1){1'b0}}, 1'b1})) == {WIDTH{1'b0}});
  endfunction

  // Returns a one-hot vector that selects bit idx.
  function automatic logic [WIDTH-1:0] index_onehot(input logic [SIZE-1:0] idx);
    return {{(WIDTH-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign beat_fire_s = out_valid & out_ready;

  // The last beat hands off to the next mask in the same cycle. This keeps
  // back-to-back masks bubble-free, at the cost of a combinational path
  // from out_ready to in_ready.
  assign in_ready    = (state_r == ST_IDLE) | (beat_fire_s & out_last);

  assign accept_s    = in_valid & in_ready;

  // Remaining bits once the presented beat has been taken.
  assign rem_after_s = rem_r & ~index_onehot(out_index);

  // Next-state and next-beat selection. The default is to hold everything,
  // which also covers a stall.
  always_comb begin
    state_s = state_r;
    rem_s   = rem_r;
    valid_s = out_valid;
    index_s = out_index;
    last_s  = out_last;
    none_s  = out_none;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_BUSY;
          rem_s   = in_mask;
          valid_s = 1'b1;
          index_s = prio_index(in_mask);
          last_s  = at_most_one(in_mask);
          none_s  = (in_mask == {WIDTH{1'b0}});
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_BUSY: begin
        if (beat_fire_s) begin
          if (out_last) begin
            if (accept_s) begin
              // The next mask's first beat follows the last beat directly.
              state_s = ST_BUSY;
              rem_s   = in_mask;
              valid_s = 1'b1;
              index_s = prio_index(in_mask);
              last_s  = at_most_one(in_mask);
              none_s  = (in_mask == {WIDTH{1'b0}});
            end else begin
              state_s = ST_IDLE;
              rem_s   = {WIDTH{1'b0}};
              valid_s = 1'b0;
              index_s = {SIZE{1'b0}};
              last_s  = 1'b0;
              none_s  = 1'b0;
            end
          end else begin
            state_s = ST_BUSY;
            rem_s   = rem_after_s;
            valid_s = 1'b1;
            index_s = prio_index(rem_after_s);
            last_s  = at_most_one(rem_after_s);
            none_s  = 1'b0;
          end
        end else begin
          // Stall, or no beat pending: hold everything.
          state_s = ST_BUSY;
        end
      end

      default: begin
        // An illegal state encoding recovers to a clean idle.
        state_s = ST_IDLE;
        rem_s   = {WIDTH{1'b0}};
        valid_s = 1'b0;
        index_s = {SIZE{1'b0}};
        last_s  = 1'b0;
        none_s  = 1'b0;
      end
    endcase
  end

  // State, remaining-bit and output registers. Reset clears them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      rem_r     <= {WIDTH{1'b0}};
      out_valid <= 1'b0;
      out_index <= {SIZE{1'b0}};
      out_last  <= 1'b0;
      out_none  <= 1'b0;
    end else begin
      state_r   <= state_s;
      rem_r     <= rem_s;
      out_valid <= valid_s;
      out_index <= index_s;
      out_last  <= last_s;
      out_none  <= none_s;
    end
  end

endmodule

// File: tb/tb_mask_index_encoder.sv
// ----------------------------------------------------------------------------
// tb_mask_index_encoder
//
// Self-checking bench for mask_index_encoder with SIZE=3 and WIDTH=8.
//
// The reference model keeps a queue of the beats still owed downstream.
// Each accepted mask is expanded into the list of its set-bit indices, in
// priority order, and appended to that queue. The model then predicts, for
// every cycle:
//   out_valid  the queue is non-empty
//   in_ready   the queue is empty, or its only beat is taken this cycle
//   beat data  the entry at the front of the queue
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mask_index_encoder;

  localparam int SIZE  = 3;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mask;
  logic             out_valid;
  logic             out_ready;
  logic [SIZE-1:0]  out_index;
  logic             out_last;
  logic             out_none;

  typedef struct packed {
    logic [SIZE-1:0] idx;
    logic            last;
    logic            none;
  } beat_t;

  beat_t q[$];
  int    total_checks = 0;
  int    fail_checks  = 0;

  mask_index_encoder #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .out_none  (out_none)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value with its expected value and counts the result.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) else begin
      fail_checks++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Appends the beats a mask is owed: its set-bit indices in priority order,
  // or one "none" beat when the mask is zero.
  task automatic push_mask(input logic [WIDTH-1:0] m);
    int    order[$];
    beat_t b;
    if (m == 8'h00) begin
      b.idx = 3'd0; b.last = 1'b1; b.none = 1'b1;
      q.push_back(b);
    end else begin
`ifdef ENCODER_MSB_FIRST_EN
      for (int i = WIDTH - 1; i >= 0; i--) if (m[i]) order.push_back(i);
`else
      for (int i = 0; i < WIDTH; i++) if (m[i]) order.push_back(i);
`endif
      foreach (order[k]) begin
        b.idx  = order[k][SIZE-1:0];
        b.last = (k == order.size() - 1);
        b.none = 1'b0;
        q.push_back(b);
      end
    end
  endtask

  // One clock cycle. It is entered 1ns after a rising edge: it drives the
  // inputs, checks the outputs against the model, steps the model across the
  // next edge and returns 1ns after that edge.
  task automatic tick(input logic iv, input logic [WIDTH-1:0] im, input logic ordy,
                      output logic accepted);
    logic exp_rdy;
    in_valid  = iv;
    in_mask   = im;
    out_ready = ordy;
    #1;
    exp_rdy = (q.size() == 0) || (ordy && q.size() == 1);
    check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    if (q.size() != 0) begin
      check("out_index", {29'd0, out_index}, {29'd0, q[0].idx});
      check("out_last", {31'd0, out_last}, {31'd0, q[0].last});
      check("out_none", {31'd0, out_none}, {31'd0, q[0].none});
    end
    accepted = iv && exp_rdy;
    @(posedge clk);
    if (ordy && q.size() != 0) void'(q.pop_front());
    if (accepted) push_mask(im);
    #1;
  endtask

  // Offers a mask until it is accepted. rnd selects a random out_ready;
  // otherwise out_ready is held high.
  task automatic send_mask(input logic [WIDTH-1:0] m, input bit rnd);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 60) begin
      tick(1'b1, m, rnd ? ($urandom_range(0, 3) != 0) : 1'b1, acc);
      n++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  // Runs with out_ready high until the model has no beats left.
  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      tick(1'b0, 8'h00, 1'b1, acc);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", 32'd0, 32'd1);
    tick(1'b0, 8'h00, 1'b1, acc);
  endtask

  initial begin
    logic       acc;
    logic [7:0] m;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mask   = 8'h00;
    out_ready = 1'b0;

    // Outputs are cleared while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_index", {29'd0, out_index}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_out_none", {31'd0, out_none}, 32'd0);
    #2 rst_n = 1'b1;
    #1 check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Single mask with out_ready held high.
    send_mask(8'b1010_0100, 1'b0);
    drain();

    // Backpressure on beat 0 of mask 0x03.
    send_mask(8'h03, 1'b0);
    repeat (3) tick(1'b0, 8'h00, 1'b0, acc);
    drain();

    // Zero mask.
    send_mask(8'h00, 1'b0);
    drain();

    // Back-to-back masks with in_valid held high.
    send_mask(8'h80, 1'b0);
    send_mask(8'h01, 1'b0);
    drain();

    // Full mask.
    send_mask(8'hFF, 1'b0);
    drain();

    // Reset asserted in the middle of a drain.
    send_mask(8'hFF, 1'b0);
    repeat (3) tick(1'b0, 8'h00, 1'b1, acc);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_index", {29'd0, out_index}, 32'd0);
    check("midrst_out_last", {31'd0, out_last}, 32'd0);
    check("midrst_out_none", {31'd0, out_none}, 32'd0);
    q.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Random masks, idle gaps and out_ready patterns.
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 2)) tick(1'b0, 8'h00, ($urandom_range(0, 3) != 0), acc);
      m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      send_mask(m, 1'b1);
    end
    drain();

    $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
    $finish;
  end

endmodule
